// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned UART_size = 8
) ();

  logic [UART_size-1:0] TX_P_DATA;
  logic                 TX_D_VLD;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic                 TX_OUT;
  logic                 busy;

  // Controller side: drives the request, watches line and busy.
  modport master (
    output TX_P_DATA,
    output TX_D_VLD,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  // Transmitter side.
  modport slave (
    input  TX_P_DATA,
    input  TX_D_VLD,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one clock per bit, frame = start, data LSB-first, optional parity, stop.
// TX_OUT and busy are registered and take the value of the state being entered.
module uart_tx #(
  parameter int unsigned UART_size = 8
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam int unsigned CntW = (UART_size > 1) ? $clog2(UART_size) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(UART_size - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [UART_size-1:0]  data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic [CntW-1:0]       cnt_nxt;

  assign cnt_nxt = cnt_q + 1'b1;

  // Next state plus the line/busy value belonging to that next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_out_d  = 1'b1;
    busy_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.TX_D_VLD) begin
          data_d    = bus.TX_P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          cnt_d     = '0;
          state_d   = StStart;
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        state_d  = StData;
        tx_out_d = data_q[0];
        busy_d   = 1'b1;
      end
      StData: begin
        busy_d = 1'b1;
        if (cnt_q == LastBit) begin
          if (par_en_q) begin
            state_d  = StParity;
            tx_out_d = (^data_q) ^ par_typ_q;
          end else begin
            state_d  = StStop;
            tx_out_d = 1'b1;
          end
        end else begin
          cnt_d    = cnt_nxt;
          tx_out_d = data_q[cnt_nxt];
        end
      end
      StParity: begin
        state_d  = StStop;
        tx_out_d = 1'b1;
        busy_d   = 1'b1;
      end
      StStop: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_out_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus random frames against a frame-queue model.
module tb_uart_tx;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  uart_tx_if #(.UART_size(W)) bus ();

  uart_tx #(.UART_size(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Model: each entry is {busy, line} for one bit period still to come.
  logic [1:0] exp_q[$];
  logic       exp_tx;
  logic       exp_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs visible at that edge.
  task automatic model_step();
    logic [1:0] e;
    if (rst) begin
      exp_q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      return;
    end
    if (exp_q.size() == 0 && bus.TX_D_VLD) begin
      exp_q.push_back(2'b10);
      for (int i = 0; i < int'(W); i++) exp_q.push_back({1'b1, bus.TX_P_DATA[i]});
      if (bus.PAR_EN) exp_q.push_back({1'b1, (^bus.TX_P_DATA) ^ bus.PAR_TYP});
      exp_q.push_back(2'b11);
      // Trailing idle bit: the edge that leaves STOP cannot accept a new request.
      exp_q.push_back(2'b01);
    end
    if (exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      exp_busy = e[1];
      exp_tx   = e[0];
    end else begin
      exp_busy = 1'b0;
      exp_tx   = 1'b1;
    end
  endtask

  // One clock: model at the rising edge, compare at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq({tag, ".tx"}, 32'(bus.TX_OUT), 32'(exp_tx));
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
  endtask

  // Pulse a request for one cycle; optionally scramble the inputs while the frame runs.
  task automatic send(input string tag, input logic [W-1:0] d, input logic pe, input logic pt,
                      input bit scramble, input int tail);
    bus.TX_P_DATA = d;
    bus.PAR_EN    = pe;
    bus.PAR_TYP   = pt;
    bus.TX_D_VLD  = 1'b1;
    cycle(tag);
    bus.TX_D_VLD  = 1'b0;
    for (int i = 0; i < tail; i++) begin
      if (scramble) begin
        bus.TX_P_DATA = W'($urandom);
        bus.PAR_EN    = 1'($urandom);
        bus.PAR_TYP   = 1'($urandom);
      end
      cycle(tag);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    exp_tx        = 1'b1;
    exp_busy      = 1'b0;
    bus.TX_P_DATA = '0;
    bus.TX_D_VLD  = 1'b0;
    bus.PAR_EN    = 1'b0;
    bus.PAR_TYP   = 1'b0;
    rst           = 1'b1;

    // Power-up reset, then idle with no request.
    #2;
    check_eq("por.tx", 32'(bus.TX_OUT), 32'd1);
    check_eq("por.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle("idle");

    // Directed frames from the plan.
    send("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 12);
    send("bb_even", 8'hBB, 1'b1, 1'b0, 1'b0, 12);
    bus.TX_P_DATA = 8'h03;
    bus.PAR_EN    = 1'b1;
    bus.PAR_TYP   = 1'b1;
    bus.TX_D_VLD  = 1'b1;
    cycle("03_odd");
    bus.TX_D_VLD  = 1'b0;
    bus.TX_P_DATA = 8'hFF;
    for (int i = 0; i < 12; i++) cycle("03_odd");

    // Request held across two frames; dropped right after the second acceptance.
    bus.TX_P_DATA = 8'h55;
    bus.PAR_EN    = 1'b0;
    bus.PAR_TYP   = 1'b0;
    bus.TX_D_VLD  = 1'b1;
    cycle("held1");
    bus.TX_P_DATA = 8'h0F;
    for (int i = 0; i < 11; i++) cycle("held1");
    check_eq("held.second_start", 32'(bus.TX_OUT), 32'd0);
    bus.TX_D_VLD = 1'b0;
    for (int i = 0; i < 12; i++) cycle("held2");

    // Reset during data bit 3 of 0xA5: outputs must drop without a clock edge.
    send("rst_mid", 8'hA5, 1'b0, 1'b0, 1'b0, 4);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid.tx", 32'(bus.TX_OUT), 32'd1);
    check_eq("rst_mid.busy", 32'(bus.busy), 32'd0);
    cycle("rst_hold");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("post_rst");
    send("3c_clean", 8'h3C, 1'b0, 1'b0, 1'b0, 12);

    // Random frames with random gaps and inputs disturbed mid-frame.
    for (int f = 0; f < 30; f++) begin
      send("rand", W'($urandom), 1'($urandom), 1'($urandom), 1'b1,
           int'($urandom_range(10, 14)));
      bus.TX_D_VLD = 1'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) cycle("rand_gap");
      bus.TX_D_VLD = 1'b0;
      for (int g = 0; g < 13; g++) cycle("rand_drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
